// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: fill, forward/reverse agitation loops with
// motor dead time, drain, repeated for each rinse pass; supports pause and abort.
module wash_sequencer #(
   parameter int TICK_WIDTH = 16,
   parameter int LOOP_WIDTH = 8,
   parameter int PASS_WIDTH = 3,
   parameter int DEAD_TICKS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  abort,
   input  logic [TICK_WIDTH-1:0] cfg_fill_ticks,
   input  logic [TICK_WIDTH-1:0] cfg_agit_ticks,
   input  logic [LOOP_WIDTH-1:0] cfg_agit_loops,
   input  logic [TICK_WIDTH-1:0] cfg_drain_ticks,
   input  logic [PASS_WIDTH-1:0] cfg_rinses,
   output logic                  ctrl_fill,
   output logic                  ctrl_release,
   output logic                  ctrl_forward,
   output logic                  ctrl_reverse,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted
);

   typedef enum logic [2:0] {
      IDLE, FILL, FWD, DEAD_F, REV, DEAD_R, DRAIN, ABORT_DRAIN
   } state_t;

   localparam logic [TICK_WIDTH-1:0] TICK_ONE = TICK_WIDTH'(1);
   localparam logic [TICK_WIDTH-1:0] DEAD_LEN = TICK_WIDTH'(DEAD_TICKS);
   localparam logic [LOOP_WIDTH-1:0] LOOP_ONE = LOOP_WIDTH'(1);
   localparam logic [PASS_WIDTH-1:0] PASS_ONE = PASS_WIDTH'(1);

   function automatic logic [TICK_WIDTH-1:0] at_least_one(input logic [TICK_WIDTH-1:0] v);
      return (v == '0) ? TICK_ONE : v;
   endfunction

   state_t                state_q, state_d;
   logic [TICK_WIDTH-1:0] tick_q, tick_d;
   logic [LOOP_WIDTH-1:0] loop_q, loop_d;
   logic [PASS_WIDTH-1:0] pass_q, pass_d;
   logic                  paused_q, paused_d;
   logic [TICK_WIDTH-1:0] fill_len_q, fill_len_d;
   logic [TICK_WIDTH-1:0] agit_len_q, agit_len_d;
   logic [TICK_WIDTH-1:0] drain_len_q, drain_len_d;
   logic [LOOP_WIDTH-1:0] loops_q, loops_d;
   logic [PASS_WIDTH-1:0] rinses_q, rinses_d;
   logic                  fill_d, release_d, forward_d, reverse_d, busy_d, done_d, aborted_d;

   // tick_q holds the cycles left in the current phase including this one;
   // paused_q marks the current cycle as frozen so it does not consume a tick.
   always_comb begin
      state_d     = state_q;
      tick_d      = tick_q;
      loop_d      = loop_q;
      pass_d      = pass_q;
      paused_d    = pause;
      fill_len_d  = fill_len_q;
      agit_len_d  = agit_len_q;
      drain_len_d = drain_len_q;
      loops_d     = loops_q;
      rinses_d    = rinses_q;
      done_d      = 1'b0;
      aborted_d   = 1'b0;

      if (state_q == IDLE) begin
         if (start) begin
            fill_len_d  = at_least_one(cfg_fill_ticks);
            agit_len_d  = at_least_one(cfg_agit_ticks);
            drain_len_d = at_least_one(cfg_drain_ticks);
            loops_d     = cfg_agit_loops;
            rinses_d    = cfg_rinses;
            pass_d      = '0;
            loop_d      = '0;
            state_d     = FILL;
            tick_d      = at_least_one(cfg_fill_ticks);
         end
      end else if (abort && state_q != ABORT_DRAIN) begin
         // Abort wins over pause so the tub always starts emptying right away.
         state_d  = ABORT_DRAIN;
         tick_d   = drain_len_q;
         paused_d = 1'b0;
      end else if (!paused_q) begin
         if (tick_q != TICK_ONE) begin
            tick_d = tick_q - TICK_ONE;
         end else begin
            unique case (state_q)
               FILL: begin
                  if (loops_q == '0) begin
                     state_d = DRAIN;
                     tick_d  = drain_len_q;
                  end else begin
                     state_d = FWD;
                     tick_d  = agit_len_q;
                     loop_d  = loops_q;
                  end
               end
               FWD: begin
                  state_d = DEAD_F;
                  tick_d  = DEAD_LEN;
               end
               DEAD_F: begin
                  state_d = REV;
                  tick_d  = agit_len_q;
               end
               REV: begin
                  state_d = DEAD_R;
                  tick_d  = DEAD_LEN;
               end
               DEAD_R: begin
                  if (loop_q != LOOP_ONE) begin
                     state_d = FWD;
                     tick_d  = agit_len_q;
                     loop_d  = loop_q - LOOP_ONE;
                  end else begin
                     state_d = DRAIN;
                     tick_d  = drain_len_q;
                  end
               end
               DRAIN: begin
                  if (pass_q < rinses_q) begin
                     state_d = FILL;
                     tick_d  = fill_len_q;
                     pass_d  = pass_q + PASS_ONE;
                  end else begin
                     state_d = IDLE;
                     tick_d  = '0;
                     done_d  = 1'b1;
                  end
               end
               ABORT_DRAIN: begin
                  state_d   = IDLE;
                  tick_d    = '0;
                  aborted_d = 1'b1;
               end
               default: begin
                  state_d = IDLE;
                  tick_d  = '0;
               end
            endcase
         end
      end

      fill_d    = (state_d == FILL) && !paused_d;
      forward_d = (state_d == FWD) && !paused_d;
      reverse_d = (state_d == REV) && !paused_d;
      release_d = (state_d == DRAIN || state_d == ABORT_DRAIN) && !paused_d;
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         tick_q       <= '0;
         loop_q       <= '0;
         pass_q       <= '0;
         paused_q     <= 1'b0;
         fill_len_q   <= '0;
         agit_len_q   <= '0;
         drain_len_q  <= '0;
         loops_q      <= '0;
         rinses_q     <= '0;
         ctrl_fill    <= 1'b0;
         ctrl_release <= 1'b0;
         ctrl_forward <= 1'b0;
         ctrl_reverse <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         aborted      <= 1'b0;
      end else begin
         state_q      <= state_d;
         tick_q       <= tick_d;
         loop_q       <= loop_d;
         pass_q       <= pass_d;
         paused_q     <= paused_d;
         fill_len_q   <= fill_len_d;
         agit_len_q   <= agit_len_d;
         drain_len_q  <= drain_len_d;
         loops_q      <= loops_d;
         rinses_q     <= rinses_d;
         ctrl_fill    <= fill_d;
         ctrl_release <= release_d;
         ctrl_forward <= forward_d;
         ctrl_reverse <= reverse_d;
         busy         <= busy_d;
         done         <= done_d;
         aborted      <= aborted_d;
      end
   end

endmodule

// File: tb/tb_wash_sequencer.sv
// Scoreboard bench for wash_sequencer: each scenario queues the expected
// per-cycle output vector from phase durations, then pops it against the DUT.
module tb_wash_sequencer;

   localparam int DEAD = 2;

   // Vector layout: {fill, release, forward, reverse, busy, done, aborted}
   localparam logic [6:0] E_IDLE = 7'b0000000;
   localparam logic [6:0] E_FILL = 7'b1000100;
   localparam logic [6:0] E_REL  = 7'b0100100;
   localparam logic [6:0] E_FWD  = 7'b0010100;
   localparam logic [6:0] E_REV  = 7'b0001100;
   localparam logic [6:0] E_OFF  = 7'b0000100;
   localparam logic [6:0] E_DONE = 7'b0000010;
   localparam logic [6:0] E_ABT  = 7'b0000001;

   logic       clk = 1'b0;
   logic       rst_n, start, pause, abort;
   logic [7:0] cfg_fill_ticks, cfg_agit_ticks, cfg_drain_ticks;
   logic [2:0] cfg_agit_loops, cfg_rinses;
   logic       ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse, busy, done, aborted;
   logic [6:0] obs;

   int compared   = 0;
   int mismatched = 0;
   logic [6:0] exp_q[$];

   assign obs = {ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse, busy, done, aborted};

   always #5 clk = ~clk;

   wash_sequencer #(
      .TICK_WIDTH(8), .LOOP_WIDTH(3), .PASS_WIDTH(3), .DEAD_TICKS(DEAD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort),
      .cfg_fill_ticks(cfg_fill_ticks), .cfg_agit_ticks(cfg_agit_ticks),
      .cfg_agit_loops(cfg_agit_loops), .cfg_drain_ticks(cfg_drain_ticks),
      .cfg_rinses(cfg_rinses),
      .ctrl_fill(ctrl_fill), .ctrl_release(ctrl_release), .ctrl_forward(ctrl_forward),
      .ctrl_reverse(ctrl_reverse), .busy(busy), .done(done), .aborted(aborted)
   );

   task automatic load_cfg(input int f, input int a, input int l, input int d, input int r);
      cfg_fill_ticks  = f[7:0];
      cfg_agit_ticks  = a[7:0];
      cfg_agit_loops  = l[2:0];
      cfg_drain_ticks = d[7:0];
      cfg_rinses      = r[2:0];
   endtask

   task automatic push_seg(input int n, input logic [6:0] v);
      for (int i = 0; i < n; i++) exp_q.push_back(v);
   endtask

   task automatic push_pass(input int f, input int a, input int l, input int d);
      push_seg((f == 0) ? 1 : f, E_FILL);
      for (int i = 0; i < l; i++) begin
         push_seg((a == 0) ? 1 : a, E_FWD);
         push_seg(DEAD, E_OFF);
         push_seg((a == 0) ? 1 : a, E_REV);
         push_seg(DEAD, E_OFF);
      end
      push_seg((d == 0) ? 1 : d, E_REL);
   endtask

   task automatic test_reset();
      logic [6:0] exp;
      rst_n = 1'b0; start = 1'b1; abort = 1'b1; pause = 1'b0;
      load_cfg(3, 4, 1, 2, 0);
      push_seg(3, E_IDLE);
      for (int c = 1; exp_q.size() > 0; c++) begin
         @(posedge clk); #1;
         exp = exp_q.pop_front();
         compared++;
         if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL reset cycle %0d: got %b expected %b", c, obs, exp);
         end
      end
      rst_n = 1'b1; start = 1'b0; abort = 1'b0;
      @(posedge clk); #1;
      compared++;
      if (obs !== E_IDLE) begin
         mismatched++;
         $display("[TB] FAIL reset_release: got %b expected %b", obs, E_IDLE);
      end
   endtask

   task automatic test_single_pass();
      logic [6:0] exp;
      load_cfg(3, 4, 1, 2, 0);
      push_pass(3, 4, 1, 2); push_seg(1, E_DONE); push_seg(2, E_IDLE);
      start = 1'b1;
      for (int c = 1; exp_q.size() > 0; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         exp = exp_q.pop_front();
         compared++;
         if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL single_pass cycle %0d: got %b expected %b", c, obs, exp);
         end
      end
   endtask

   task automatic test_rinse();
      logic [6:0] exp;
      logic       prev_fill = 1'b0;
      int         fill_pulses = 0;
      load_cfg(3, 4, 1, 2, 1);
      push_pass(3, 4, 1, 2); push_pass(3, 4, 1, 2);
      push_seg(1, E_DONE); push_seg(2, E_IDLE);
      start = 1'b1;
      for (int c = 1; exp_q.size() > 0; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (ctrl_fill && !prev_fill) fill_pulses++;
         prev_fill = ctrl_fill;
         exp = exp_q.pop_front();
         compared++;
         if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL rinse cycle %0d: got %b expected %b", c, obs, exp);
         end
      end
      compared++;
      if (fill_pulses !== 2) begin
         mismatched++;
         $display("[TB] FAIL rinse_fill_pulses: got %0d expected 2", fill_pulses);
      end
   endtask

   task automatic test_pause();
      logic [6:0] exp;
      load_cfg(3, 4, 1, 2, 0);
      push_seg(3, E_FILL); push_seg(1, E_FWD); push_seg(5, E_OFF); push_seg(3, E_FWD);
      push_seg(2, E_OFF); push_seg(4, E_REV); push_seg(2, E_OFF); push_seg(2, E_REL);
      push_seg(1, E_DONE); push_seg(2, E_IDLE);
      start = 1'b1;
      for (int c = 1; exp_q.size() > 0; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         exp = exp_q.pop_front();
         compared++;
         if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL pause cycle %0d: got %b expected %b", c, obs, exp);
         end
         pause = (c >= 4 && c <= 8);
      end
      pause = 1'b0;
   endtask

   task automatic test_abort();
      logic [6:0] exp;
      load_cfg(3, 4, 1, 2, 0);
      push_seg(3, E_FILL); push_seg(4, E_FWD); push_seg(2, E_OFF); push_seg(2, E_REV);
      push_seg(2, E_REL); push_seg(1, E_ABT); push_seg(3, E_IDLE);
      start = 1'b1;
      for (int c = 1; exp_q.size() > 0; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         exp = exp_q.pop_front();
         compared++;
         if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL abort cycle %0d: got %b expected %b", c, obs, exp);
         end
         abort = (c == 11);
         pause = (c == 11);
      end
      abort = 1'b0; pause = 1'b0;
   endtask

   task automatic test_zero_cfg();
      logic [6:0] exp;
      load_cfg(0, 4, 0, 0, 0);
      push_seg(1, E_FILL); push_seg(1, E_REL); push_seg(1, E_DONE); push_seg(2, E_IDLE);
      start = 1'b1;
      for (int c = 1; exp_q.size() > 0; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         exp = exp_q.pop_front();
         compared++;
         if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL zero_cfg cycle %0d: got %b expected %b", c, obs, exp);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [6:0] exp;
      load_cfg(3, 4, 1, 2, 0);
      push_seg(3, E_FILL); push_seg(3, E_FWD); push_seg(6, E_IDLE);
      push_pass(3, 4, 1, 2); push_seg(1, E_DONE); push_seg(2, E_IDLE);
      start = 1'b1;
      for (int c = 1; exp_q.size() > 0; c++) begin
         @(posedge clk); #1;
         exp = exp_q.pop_front();
         compared++;
         if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL reset_mid cycle %0d: got %b expected %b", c, obs, exp);
         end
         rst_n = !(c >= 6 && c <= 9);
         start = (c >= 6 && c <= 9) || (c == 12);
      end
      rst_n = 1'b1; start = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [6:0] exp;
      load_cfg(3, 4, 1, 2, 0);
      push_pass(3, 4, 1, 2); push_seg(1, E_DONE);
      push_seg(1, E_FILL); push_seg(1, E_REL); push_seg(1, E_DONE); push_seg(2, E_IDLE);
      start = 1'b1;
      for (int c = 1; exp_q.size() > 0; c++) begin
         @(posedge clk); #1;
         exp = exp_q.pop_front();
         compared++;
         if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b", c, obs, exp);
         end
         start = (c <= 18);
         if (c == 2) load_cfg(1, 1, 0, 1, 0);
      end
      start = 1'b0;
   endtask

   task automatic test_max_ticks();
      logic [6:0] exp;
      load_cfg(255, 1, 7, 1, 0);
      push_pass(255, 1, 7, 1); push_seg(1, E_DONE); push_seg(2, E_IDLE);
      start = 1'b1;
      for (int c = 1; exp_q.size() > 0; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         exp = exp_q.pop_front();
         compared++;
         if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL max_ticks cycle %0d: got %b expected %b", c, obs, exp);
         end
      end
   endtask

   task automatic test_max_rinses();
      logic [6:0] exp;
      load_cfg(1, 3, 0, 1, 7);
      for (int p = 0; p < 8; p++) push_pass(1, 3, 0, 1);
      push_seg(1, E_DONE); push_seg(2, E_IDLE);
      start = 1'b1;
      for (int c = 1; exp_q.size() > 0; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         exp = exp_q.pop_front();
         compared++;
         if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL max_rinses cycle %0d: got %b expected %b", c, obs, exp);
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_single_pass();
      test_rinse();
      test_pause();
      test_abort();
      test_zero_cfg();
      test_reset_mid();
      test_back_to_back();
      test_max_ticks();
      test_max_rinses();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
